// File: rtl/seg_scan.sv
// Time-multiplexed hex display scanner: frame-synchronous snapshot of a data page,
// per-digit hex decode with leading-zero blanking, blink, decimal points and guard time.
module seg_scan #(
    parameter int unsigned DW           = 32,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned GUARD        = 2,
    parameter int unsigned BLINK_FRAMES = 64,
    localparam int unsigned PAGES       = DW / (4 * DIGITS),
    localparam int unsigned SW          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DW-1:0]     din,
    input  logic [SW-1:0]     sel,
    input  logic              lz_blank,
    input  logic [DIGITS-1:0] blink,
    input  logic [DIGITS-1:0] dp,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              frame
);

    localparam int unsigned PW = 4 * DIGITS;
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [FW-1:0]     r_fcnt;
    logic              r_phase;

    logic [DW-1:0]     r_din;
    logic [SW-1:0]     r_sel;
    logic              r_lz;
    logic [DIGITS-1:0] r_blink;
    logic [DIGITS-1:0] r_dp;

    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_an;
    logic              r_frame;

    logic              w_cnt_last;
    logic              w_frame_end;
    logic              w_snap;
    logic              w_lit;
    logic [PW-1:0]     w_page;
    logic [DIGITS-1:0] w_zmask;
    logic [3:0]        w_nib;
    logic              w_zero_sel;
    logic              w_dp_sel;
    logic              w_blink_sel;
    logic [7:0]        w_seg;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign w_cnt_last  = (r_cnt == CW'(PRESCALE - 1));
    assign w_frame_end = w_cnt_last && (r_idx == IW'(DIGITS - 1));
    assign w_snap      = (r_cnt == '0) && (r_idx == '0);
    assign w_lit       = (r_cnt >= CW'(GUARD));

    // Page select; out-of-range selects fall back to page 0
    always_comb begin
        w_page = r_din[PW-1:0];
        for (int p = 1; p < int'(PAGES); p++) begin
            if (r_sel == SW'(p)) begin
                w_page = r_din[p*PW +: PW];
            end
        end
    end

    // w_zmask[i] set when nibbles i..DIGITS-1 are all zero
    always_comb begin
        logic v_allz;
        v_allz  = 1'b1;
        w_zmask = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            v_allz     = v_allz && (w_page[4*i +: 4] == 4'h0);
            w_zmask[i] = v_allz;
        end
    end

    always_comb begin
        w_nib       = '0;
        w_zero_sel  = 1'b0;
        w_dp_sel    = 1'b0;
        w_blink_sel = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_idx == IW'(i)) begin
                w_nib       = w_page[4*i +: 4];
                w_zero_sel  = w_zmask[i];
                w_dp_sel    = r_dp[i];
                w_blink_sel = r_blink[i];
            end
        end
    end

    always_comb begin
        w_seg = {w_dp_sel, hex7(w_nib)};
        if (r_lz && (r_idx != '0) && w_zero_sel) begin
            w_seg[6:0] = 7'h00;
        end
        if (r_phase && w_blink_sel) begin
            w_seg = 8'h00;
        end
    end

    // Slot/digit timing and blink phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            if (w_cnt_last) begin
                r_cnt <= '0;
                if (r_idx == IW'(DIGITS - 1)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_frame_end) begin
                if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + FW'(1);
                end
            end
        end
    end

    // Shadow of the display inputs, refreshed only at frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_din   <= '0;
            r_sel   <= '0;
            r_lz    <= 1'b0;
            r_blink <= '0;
            r_dp    <= '0;
        end else if (w_snap) begin
            r_din   <= din;
            r_sel   <= sel;
            r_lz    <= lz_blank;
            r_blink <= blink;
            r_dp    <= dp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg   <= 8'h00;
            r_an    <= '0;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_lit ? w_seg : 8'h00;
            r_an    <= w_lit ? (DIGITS'(1) << r_idx) : '0;
            r_frame <= w_frame_end;
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign frame = r_frame;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: a 32-bit/4-digit instance and a 24-bit/2-digit
// instance (three pages) with short prescale, guard and blink periods.
module tb_seg_scan;

    logic        clk;
    logic        reset_n;

    logic [31:0] din_a;
    logic [0:0]  sel_a;
    logic        lz_a;
    logic [3:0]  blink_a;
    logic [3:0]  dp_a;
    logic [7:0]  seg_a;
    logic [3:0]  an_a;
    logic        frame_a;

    logic [23:0] din_b;
    logic [1:0]  sel_b;
    logic        lz_b;
    logic [1:0]  blink_b;
    logic [1:0]  dp_b;
    logic [7:0]  seg_b;
    logic [1:0]  an_b;
    logic        frame_b;

    int n_checks;
    int n_fail;
    int e;

    seg_scan #(
        .DW(32), .DIGITS(4), .PRESCALE(4), .GUARD(1), .BLINK_FRAMES(2)
    ) u_dut_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (din_a),
        .sel      (sel_a),
        .lz_blank (lz_a),
        .blink    (blink_a),
        .dp       (dp_a),
        .seg      (seg_a),
        .an       (an_a),
        .frame    (frame_a)
    );

    seg_scan #(
        .DW(24), .DIGITS(2), .PRESCALE(4), .GUARD(1), .BLINK_FRAMES(1)
    ) u_dut_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (din_b),
        .sel      (sel_b),
        .lz_blank (lz_b),
        .blink    (blink_b),
        .dp       (dp_b),
        .seg      (seg_b),
        .an       (an_b),
        .frame    (frame_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] x_an, input logic [7:0] x_seg);
        check({tag, "_an"}, 32'(an_a), 32'(x_an));
        check({tag, "_seg"}, 32'(seg_a), 32'(x_seg));
    endtask

    task automatic chk_b(input string tag, input logic [1:0] x_an, input logic [7:0] x_seg);
        check({tag, "_an"}, 32'(an_b), 32'(x_an));
        check({tag, "_seg"}, 32'(seg_b), 32'(x_seg));
    endtask

    // Advance to edge number 'target' after reset release, sampling 1 time unit later
    task automatic goto(input int target);
        while (e < target) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        e        = 0;
        reset_n  = 1'b0;
        din_a    = 32'h1234ABCD;
        sel_a    = 1'b0;
        lz_a     = 1'b0;
        blink_a  = 4'b0000;
        dp_a     = 4'b0100;
        din_b    = 24'hABCDEF;
        sel_b    = 2'd3;
        lz_b     = 1'b0;
        blink_b  = 2'b00;
        dp_b     = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        chk_a("rst", 4'b0000, 8'h00);
        check("rst_frame", 32'(frame_a), 32'h0);
        reset_n = 1'b1;

        // Frame 1: page 0 of 1234ABCD, dp on digit 2
        goto(1);  check("f1_guard_an", 32'(an_a), 32'h0);
                  check("f1_frame_lo", 32'(frame_a), 32'h0);
        goto(2);  chk_a("f1_d0", 4'b0001, 8'h5E);
                  chk_b("b_sel3_d0", 2'b01, 8'h71);
        goto(4);  chk_a("f1_d0_end", 4'b0001, 8'h5E);
        goto(5);  check("f1_guard1_an", 32'(an_a), 32'h0);
        goto(6);  chk_a("f1_d1", 4'b0010, 8'h39);
                  chk_b("b_sel3_d1", 2'b10, 8'h79);
        sel_a = 1'b1;
        sel_b = 2'd2;
        goto(8);  check("b_frame", 32'(frame_b), 32'h1);
        goto(10); chk_a("f1_d2_dp", 4'b0100, 8'hFC);
                  chk_b("b_sel2_d0", 2'b01, 8'h7C);
        goto(14); chk_a("f1_d3", 4'b1000, 8'h77);
                  chk_b("b_sel2_d1", 2'b10, 8'h77);
        goto(15); check("f1_frame_pre", 32'(frame_a), 32'h0);
        goto(16); check("f1_frame", 32'(frame_a), 32'h1);
                  chk_a("f1_d3_last", 4'b1000, 8'h77);
        goto(17); check("f2_frame_post", 32'(frame_a), 32'h0);
                  check("f2_guard_an", 32'(an_a), 32'h0);

        // Frame 2: page 1; inputs changed mid-frame stay hidden
        goto(18); chk_a("f2_d0", 4'b0001, 8'h66);
        goto(20);
        din_a   = 32'h00000020;
        sel_a   = 1'b0;
        lz_a    = 1'b1;
        blink_a = 4'b0001;
        goto(22); chk_a("f2_d1_held", 4'b0010, 8'h4F);
        goto(26); chk_a("f2_d2_held", 4'b0100, 8'hDB);
        goto(30); chk_a("f2_d3_held", 4'b1000, 8'h06);
        goto(32); check("f2_frame", 32'(frame_a), 32'h1);

        // Frames 3-4: blink phase 1, leading-zero blanking on then off
        goto(34); chk_a("f3_d0_blink", 4'b0001, 8'h00);
        goto(38); chk_a("f3_d1", 4'b0010, 8'h5B);
        goto(40); lz_a = 1'b0;
        goto(42); chk_a("f3_d2_lz_dp", 4'b0100, 8'h80);
        goto(46); chk_a("f3_d3_lz", 4'b1000, 8'h00);
        goto(48); check("f3_frame", 32'(frame_a), 32'h1);
        goto(50); chk_a("f4_d0_blink", 4'b0001, 8'h00);
        goto(56);
        din_a = 32'h00000000;
        lz_a  = 1'b1;
        goto(58); chk_a("f4_d2_nolz", 4'b0100, 8'hBF);
        goto(62); chk_a("f4_d3_nolz", 4'b1000, 8'h3F);

        // Frame 5: blink phase back to 0, all-zero word with blanking
        goto(66); chk_a("f5_d0_unblank", 4'b0001, 8'h3F);
        goto(70); chk_a("f5_d1_lz", 4'b0010, 8'h00);
        goto(72);
        din_a = 32'h00000007;
        lz_a  = 1'b0;

        // Frame 6: reset mid-slot of digit 2
        goto(90); chk_a("f6_d2", 4'b0100, 8'hBF);
        #2;
        reset_n = 1'b0;
        #1;
        chk_a("async_rst", 4'b0000, 8'h00);
        check("async_rst_frame", 32'(frame_a), 32'h0);
        din_a = 32'h0000000E;
        @(posedge clk);
        #1;
        chk_a("rst_hold", 4'b0000, 8'h00);
        reset_n = 1'b1;
        e = 0;
        goto(1);  check("rel_guard_an", 32'(an_a), 32'h0);
        goto(2);  chk_a("rel_d0_new", 4'b0001, 8'h79);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed hex display scanner: takes a DW-bit word, selects one page of 4·DIGITS bits, and drives a common-segment seven-segment display one digit at a time, with a registered segment/anode output. Sits between the CPU output-port register and the board display pins. Generalises the static word-to-segment decoder with page selection, scanning, anti-ghosting guard time, leading-zero blanking, per-digit blink and decimal points.

## Interface
- DW, 32, input data width; must be a multiple of 4·DIGITS
- DIGITS, 4, number of display digits (1..8)
- PRESCALE, 50000, clock cycles per digit slot (≥ 2)
- GUARD, 2, blanked cycles at the start of each slot (1..PRESCALE-1)
- BLINK_FRAMES, 64, frames per blink half-period (≥ 1)
- Derived: PAGES = DW/(4·DIGITS); SW = max(1, clog2(PAGES))

Ports:
- clk  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- din  in  DW  data word
- sel  in  SW  page select; page p shows din[16·…] bits [4·DIGITS·(p+1)-1 : 4·DIGITS·p]
- lz_blank  in  1  enable leading-zero blanking
- blink  in  DIGITS  per-digit blink enable
- dp  in  DIGITS  per-digit decimal point
- seg  out  8  segments, active-high, seg[6:0]=g..a, seg[7]=dp
- an  out  DIGITS  digit enable, active-high, at most one bit set
- frame  out  1  one-cycle pulse per completed scan frame

## Operation
- Prescaler cnt counts 0..PRESCALE-1, wraps to 0; on wrap, digit index idx increments 0..DIGITS-1, wraps to 0.
- Snapshot: when cnt==0 and idx==0, din, sel, lz_blank, blink, dp are latched into a shadow register; display content only changes at frame boundaries (no tearing). Shadow resets to 0.
- sel ≥ PAGES (non-power-of-two PAGES) selects page 0.
- Nibble for digit i = selected page bits [4i+3:4i]; digit 0 is rightmost (an[0]).
- Hex decode (g..a): 0→3F 1→06 2→5B 3→4F 4→66 5→6D 6→7D 7→07 8→7F 9→6F A→77 B→7C C→39 D→5E E→79 F→71.
- Leading-zero blanking: if shadow lz_blank, digit i>0 has seg[6:0]=0 when nibbles i..DIGITS-1 are all zero; digit 0 never blanked. dp unaffected.
- Blink: phase bit toggles after every BLINK_FRAMES completed frames; while phase=1, digits with shadow blink[i]=1 output seg=8'h00 (dp included).
- seg[7] = shadow dp[idx] unless blink-suppressed.

## Timing
- Reset (async, reset_n low): cnt=0, idx=0, phase=0, shadow=0, seg=8'h00, an=0, frame=0.
- All outputs are registered; output in cycle n+1 reflects state (cnt, idx, shadow, phase) of cycle n.
- an = one-hot(idx) when cnt ≥ GUARD, else 0; guard hides idx/seg transitions and the shadow update (GUARD ≥ 1 guaranteed).
- seg is valid from the first cycle an is set through the end of the slot.
- frame = 1 for one cycle following the state cnt==PRESCALE-1, idx==DIGITS-1; frame period = PRESCALE·DIGITS cycles.
- Blink phase toggles in the same cycle the BLINK_FRAMES-th frame pulse is generated; frame counter wraps.
- First snapshot is taken in the first clock after reset_n deasserts; first digit lit GUARD+1 cycles after that.
- reset_n asserted mid-slot: an and seg drop to 0 immediately (asynchronously), scan restarts at digit 0.
- Input changes mid-frame are invisible until next frame start.

## Test plan
- DW=32, DIGITS=4, PRESCALE=4, GUARD=1: din=32'h1234ABCD, sel=0 → an cycles 0001,0010,0100,1000 with seg 5E,39,7C,77; an=0 for 1 cycle at each slot start; frame every 16 cycles.
- Same, sel=1 → seg 66,4F,5B,06; change din mid-frame → old value held until next frame start.
- din=32'h00000020, lz_blank=1, sel=0 → digits 0,1 show 3F,5B; digits 2,3 seg=00; with lz_blank=0 all digits lit, digit 3 = 3F.
- blink=4'b0001, BLINK_FRAMES=2 → digit 0 lit for 2 frames, seg=00 for 2 frames, repeating; other digits unaffected; dp=4'b0100 → seg[7]=1 only during digit 2 slot.
- Assert reset_n low mid-slot of digit 2 → an=0, seg=00, frame=0 same cycle; after release, digit 0 lit GUARD+1 cycles later with newly sampled din.
- DW=24, DIGITS=2 (PAGES=3, SW=2): sel=3 → page 0 displayed; sel=2 → din[23:16].
